// File: rtl/ntr_cmd_dispatch.sv
// Command dispatcher: latches a decoded command and streams 32-bit response words.
// Optional macro NTR_HEADER_EN: opcode 0x00 returns a 128-word index header.
module ntr_cmd_dispatch (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cmd,
  input  logic        cmd_ready,
  input  logic        word_req,
  output logic [31:0] data_word,
  output logic        word_valid,
  output logic        led,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RESPOND,
    DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_q;
  logic        arm_q;
  logic [7:0]  op_q, op_d;
  logic [10:0] idx_q, idx_d;
  logic [10:0] last_q, last_d;
  logic        unl_q, unl_d;
  logic [31:0] dw_q, dw_d;
  logic        wv_q, wv_d;
  logic        led_q, led_d;
  logic        ovr_q, ovr_d;

  logic        start;
  logic [7:0]  w_op;
  logic [10:0] w_n;
  logic [31:0] w_data;
  logic        unused_ok;

  // arm_q blocks a cmd_ready left high across reset from starting a command
  assign start = cmd_ready & ~rdy_q & arm_q;

`ifdef NTR_HEADER_EN
  assign unused_ok = ^{cmd[63:57], cmd[55:8]};
`else
  assign unused_ok = ^{cmd[63:57], cmd[55:8], w_n};
`endif

  always_comb begin
    w_op = (state_q == LOAD) ? cmd[7:0] : op_q;
    w_n  = (state_q == LOAD) ? 11'd0 : idx_q + 11'd1;
    case (w_op)
      8'h9F:   w_data = 32'hFFFF_FFFF;
      8'h90:   w_data = 32'h807F_01E0;
      8'hFF:   w_data = 32'd1;
`ifdef NTR_HEADER_EN
      8'h00:   w_data = {21'd0, w_n};
`endif
      default: w_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unl_d   = unl_q;
    dw_d    = dw_q;
    wv_d    = wv_q;
    led_d   = led_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (!cmd_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESPOND;
          op_d    = cmd[7:0];
          idx_d   = 11'd0;
          ovr_d   = 1'b0;
          wv_d    = 1'b1;
          dw_d    = w_data;
          unl_d   = 1'b0;
          last_d  = 11'd0;
          case (cmd[7:0])
            8'h9F:   last_d = 11'd2047;
            8'h90:   unl_d  = 1'b1;
            8'hFF:   led_d  = cmd[56];
`ifdef NTR_HEADER_EN
            8'h00:   last_d = 11'd127;
`endif
            default: last_d = 11'd0;
          endcase
        end
      end
      RESPOND: begin
        if (!cmd_ready) begin
          state_d = IDLE;
          wv_d    = 1'b0;
          dw_d    = 32'd0;
        end else if (word_req && wv_q) begin
          if (!unl_q && idx_q == last_q) begin
            state_d = DRAIN;
            wv_d    = 1'b0;
            dw_d    = 32'd0;
          end else begin
            idx_d = idx_q + 11'd1;
            dw_d  = w_data;
          end
        end
      end
      DRAIN: begin
        if (!cmd_ready) begin
          state_d = IDLE;
        end else if (word_req) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      arm_q   <= 1'b0;
      op_q    <= 8'd0;
      idx_q   <= 11'd0;
      last_q  <= 11'd0;
      unl_q   <= 1'b0;
      dw_q    <= 32'd0;
      wv_q    <= 1'b0;
      led_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= cmd_ready;
      arm_q   <= arm_q | ~cmd_ready;
      op_q    <= op_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      unl_q   <= unl_d;
      dw_q    <= dw_d;
      wv_q    <= wv_d;
      led_q   <= led_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_word  = dw_q;
  assign word_valid = wv_q;
  assign led        = led_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = ovr_q;

endmodule
